// File: rtl/nibble_ser_pkg.sv
// rtl/nibble_ser_pkg.sv - shared state encodings and sizing helpers for the nibble serializer
package nibble_ser_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef NIBBLE_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    // Counter width for 0..n-1, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit cycle counter, cleared while idle, ticks on terminal count
module bit_timer
    import nibble_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic i_run,
    output logic o_tick,
    output logic o_tick_next
);

    localparam int TW = cnt_w(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE  = TW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (!i_run || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);
    // Lets the owner register a pulse that lands exactly on the terminal cycle
    assign o_tick_next = (CLKS_PER_BIT == 1) || (r_cnt == PRE);

endmodule

// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - LSB-first start/data/stop serializer; NIBBLE_SER_PARITY_EN adds even parity
module nibble_serializer
    import nibble_ser_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_ser,
    output logic             o_busy,
    output logic             o_done
);

    localparam int IW = cnt_w(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
    localparam logic DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [IW-1:0]    r_idx;
    logic             r_ser;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_tick;
    logic             w_tick_next;
`ifdef NIBBLE_SER_PARITY_EN
    logic             r_parity;
`endif

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk         (clk),
        .n_reset     (n_reset),
        .i_run       (r_busy),
        .o_tick      (w_tick),
        .o_tick_next (w_tick_next)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_idx    <= '0;
            r_ser    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef NIBBLE_SER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_shreg  <= i_data;
`ifdef NIBBLE_SER_PARITY_EN
                        r_parity <= ^i_data;
`endif
                        r_state  <= S_START;
                        r_ser    <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                        r_ser   <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_idx == LAST_IDX) begin
`ifdef NIBBLE_SER_PARITY_EN
                            r_state <= S_PARITY;
                            r_ser   <= r_parity;
`else
                            r_state <= S_STOP;
                            r_ser   <= 1'b1;
                            r_done  <= DONE_ON_ENTRY;
`endif
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_ser   <= r_shreg[0];
                            r_shreg <= r_shreg >> 1;
                        end
                    end
                end
`ifdef NIBBLE_SER_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_ser   <= 1'b1;
                        r_done  <= DONE_ON_ENTRY;
                    end
                end
`endif
                S_STOP: begin
                    // o_done is registered one cycle ahead so it covers the final STOP cycle
                    if (w_tick) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_done  <= w_tick_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ser   <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_ser   = r_ser;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
